// File: rtl/bath_pkg.sv
// Shared definitions for the bathysphere signal initiator.
// Holds the 2-bit signal encodings, the controller state encoding and
// a small constant helper used to size the shared cycle timer.
package bath_pkg;

    // Encoding of the signal driven to the docking receiver; 2'b11 is never driven.
    typedef enum logic [1:0] {
        SIG_IDLE   = 2'b00,
        SIG_ARRIVE = 2'b01,
        SIG_DEPART = 2'b10
    } bath_sig_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ASSERT  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_RELEASE = 3'd3,
        ST_ERROR   = 3'd4
    } bath_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/bath_cycle_timer.sv
// Clear/enable saturating cycle counter with a compare-to-limit flag.
// Ports: clk/rst (async active-high), clr_i, en_i, limit_i in; hit_o out.
// hit_o is high when the cycle being counted now is the limit_i-th one
// (count + 1 >= limit), so a state can leave on exactly that edge.
module bath_cycle_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         hit_o
);

    logic [W-1:0] count_q;
    logic [W:0]   count_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    // One bit wider so a saturated count still compares correctly.
    assign count_nxt = {1'b0, count_q} + {{W{1'b0}}, 1'b1};
    assign hit_o     = (count_nxt >= {1'b0, limit_i});

endmodule

// File: rtl/bath_signal_initiator.sv
// Drives the 2-bit bathysphere arrival/departure signal into the docking
// receiver, holds it until the matching ack, then releases it; flags a
// receiver that never acks (ERROR until clearErr).
// Ports: clk, reset (async active-high), arriveReq/departReq/clearErr
// requests, arriving/departing acks in; bathysphereSignal, busy, done, error out.
// Optional feature macro: BATH_REQ_QUEUE_EN (one-entry pending request slot).
module bath_signal_initiator
    import bath_pkg::*;
#(
    parameter int ACK_TIMEOUT = 15,
    parameter int HOLD_CYCLES = 2,
    parameter int GAP_CYCLES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arriveReq,
    input  logic       departReq,
    input  logic       clearErr,
    input  logic       arriving,
    input  logic       departing,
    output logic [1:0] bathysphereSignal,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int TW = $clog2(max3(ACK_TIMEOUT, HOLD_CYCLES, GAP_CYCLES) + 1);

    bath_state_e state_q, state_d;
    bath_sig_e   code_q, code_d;
    bath_sig_e   req_code;
    logic        req_vld;
    logic        ack_match, ack_other;
    logic        tmr_clr, tmr_en, tmr_hit;
    logic [TW-1:0] tmr_limit;
    logic [1:0]  sig_q;
    logic        busy_q, done_q, error_q;
`ifdef BATH_REQ_QUEUE_EN
    logic        pend_vld_q, pend_vld_d;
    bath_sig_e   pend_code_q, pend_code_d;
`endif

    // Arrive wins a same-cycle tie; the depart request is simply lost.
    assign req_vld  = arriveReq | departReq;
    assign req_code = arriveReq ? SIG_ARRIVE : SIG_DEPART;

    assign ack_match = (code_q == SIG_ARRIVE) ? arriving  : departing;
    assign ack_other = (code_q == SIG_ARRIVE) ? departing : arriving;

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
`ifdef BATH_REQ_QUEUE_EN
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        // First request seen while busy is parked; later ones are dropped.
        if (!pend_vld_q && req_vld &&
            (state_q == ST_ASSERT || state_q == ST_HOLD || state_q == ST_RELEASE)) begin
            pend_vld_d  = 1'b1;
            pend_code_d = req_code;
        end
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_vld) begin
                    state_d = ST_ASSERT;
                    code_d  = req_code;
                end
            end
            ST_ASSERT: begin
                // A wrong-direction ack is a receiver fault even if the right one is also up.
                if (ack_other) begin
                    state_d = ST_ERROR;
                end else if (ack_match) begin
                    state_d = ST_HOLD;
                end else if (tmr_hit) begin
                    state_d = ST_ERROR;
                end
            end
            ST_HOLD: begin
                if (tmr_hit) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                // Wait for the receiver to drop its ack; no timeout here.
                if (tmr_hit && !arriving && !departing) begin
`ifdef BATH_REQ_QUEUE_EN
                    if (pend_vld_q) begin
                        state_d    = ST_ASSERT;
                        code_d     = pend_code_q;
                        pend_vld_d = 1'b0;
                    end else if (req_vld) begin
                        // A request landing on the exit edge is issued directly.
                        state_d    = ST_ASSERT;
                        code_d     = req_code;
                        pend_vld_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                    end
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_ERROR: begin
                if (clearErr) begin
                    state_d = ST_IDLE;
`ifdef BATH_REQ_QUEUE_EN
                    pend_vld_d = 1'b0;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // One timer serves every state; any state change restarts it.
    assign tmr_clr = (state_d != state_q);
    assign tmr_en  = (state_q == ST_ASSERT) || (state_q == ST_HOLD) || (state_q == ST_RELEASE);

    always_comb begin
        tmr_limit = '0;
        case (state_q)
            ST_ASSERT:  tmr_limit = TW'(ACK_TIMEOUT);
            ST_HOLD:    tmr_limit = TW'(HOLD_CYCLES);
            ST_RELEASE: tmr_limit = TW'(GAP_CYCLES);
            default:    tmr_limit = '0;
        endcase
    end

    bath_cycle_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst     (reset),
        .clr_i   (tmr_clr),
        .en_i    (tmr_en),
        .limit_i (tmr_limit),
        .hit_o   (tmr_hit)
    );

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            code_q  <= SIG_IDLE;
            sig_q   <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
`ifdef BATH_REQ_QUEUE_EN
            pend_vld_q  <= 1'b0;
            pend_code_q <= SIG_IDLE;
`endif
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            sig_q   <= ((state_d == ST_ASSERT) || (state_d == ST_HOLD)) ? code_d : SIG_IDLE;
            busy_q  <= (state_d == ST_ASSERT) || (state_d == ST_HOLD) || (state_d == ST_RELEASE);
            done_q  <= (state_q == ST_HOLD) && (state_d == ST_RELEASE);
            error_q <= (state_d == ST_ERROR);
`ifdef BATH_REQ_QUEUE_EN
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
`endif
        end
    end

    assign bathysphereSignal = sig_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign error             = error_q;

endmodule

// File: tb/tb_bath_signal_initiator.sv
// Bench for bath_signal_initiator: pairs the DUT with a 5-cycle receiver
// model; each expected signal segment (code, first/last cycle, done) is
// queued when a request is driven and compared when the segment ends.
module tb_bath_signal_initiator;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       arriveReq = 1'b0;
    logic       departReq = 1'b0;
    logic       clearErr = 1'b0;
    logic       arriving;
    logic       departing;
    logic [1:0] sig;
    logic       busy, done, error;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0] code;
        int         s;
        int         e;
        logic       dn;
    } seg_t;
    seg_t exp_q[$];

    bath_signal_initiator dut (
        .clk               (clk),
        .reset             (reset),
        .arriveReq         (arriveReq),
        .departReq         (departReq),
        .clearErr          (clearErr),
        .arriving          (arriving),
        .departing         (departing),
        .bathysphereSignal (sig),
        .busy              (busy),
        .done              (done),
        .error             (error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Receiver model: latches the ack after the signal is seen stable for 5 samples.
    logic [1:0] rx_last = 2'b00;
    int         rx_cnt = 0;
    logic       arr_m = 1'b0, dep_m = 1'b0;
    logic       ack_en = 1'b1;
    logic       force_dep = 1'b0;

    always @(posedge clk) begin
        rx_last <= sig;
        if (sig == 2'b00 || sig != rx_last) begin
            rx_cnt <= (sig == 2'b00) ? 0 : 1;
            arr_m  <= 1'b0;
            dep_m  <= 1'b0;
        end else if (rx_cnt < 5) begin
            rx_cnt <= rx_cnt + 1;
        end else if (ack_en) begin
            arr_m <= (sig == 2'b01);
            dep_m <= (sig == 2'b10);
        end
    end
    assign arriving  = arr_m;
    assign departing = dep_m | force_dep;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Segment monitor: scoreboard pop on every nonzero -> zero transition of the signal.
    logic [1:0] mon_prev = 2'b00;
    logic [1:0] mon_code = 2'b00;
    int         mon_start = 0;
    always @(negedge clk) begin
        seg_t e;
        if (mon_prev == 2'b00 && sig != 2'b00) begin
            mon_code  = sig;
            mon_start = cyc;
        end
        if (mon_prev != 2'b00 && sig == 2'b00) begin
            if (exp_q.size() == 0) begin
                chk("extra_segment", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("seg_code",  32'(mon_code),  32'(e.code));
                chk("seg_start", 32'(mon_start), 32'(e.s));
                chk("seg_end",   32'(cyc),       32'(e.e));
                chk("seg_done",  32'(done),      32'(e.dn));
            end
        end
        mon_prev = sig;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_seg(input logic [1:0] code, input int s, input int e, input logic dn);
        seg_t x;
        x.code = code; x.s = s; x.e = e; x.dn = dn;
        exp_q.push_back(x);
    endtask

    // Nominal arrival: 01 from cycle 1, done at 10, idle at 12.
    task automatic run_nominal(input string tag);
        int n0;
        n0 = cyc;
        push_seg(2'b01, n0 + 1, n0 + 10, 1'b1);
        arriveReq = 1'b1;
        tick(1);
        arriveReq = 1'b0;
        chk({tag, "_sig_c1"}, 32'(sig), 32'h1);
        chk({tag, "_busy_c1"}, 32'(busy), 32'h1);
        tick(8);
        chk({tag, "_sig_c9"}, 32'(sig), 32'h1);
        chk({tag, "_done_c9"}, 32'(done), 32'h0);
        tick(1);
        chk({tag, "_done_c10"}, 32'(done), 32'h1);
        tick(1);
        chk({tag, "_done_c11"}, 32'(done), 32'h0);
        chk({tag, "_busy_c11"}, 32'(busy), 32'h1);
        tick(1);
        chk({tag, "_busy_c12"}, 32'(busy), 32'h0);
        chk({tag, "_err_c12"}, 32'(error), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int n0;
        int gaps;

        // Reset state
        tick(2);
        chk("rst_sig", 32'(sig), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err", 32'(error), 32'h0);
        reset = 1'b0;
        tick(3);

        // Nominal arrival
        run_nominal("nom");
        tick(3);

        // Departure with no ack: timeout after 15 cycles of 10
        ack_en = 1'b0;
        n0 = cyc;
        push_seg(2'b10, n0 + 1, n0 + 16, 1'b0);
        departReq = 1'b1;
        tick(1);
        departReq = 1'b0;
        chk("to_sig_c1", 32'(sig), 32'h2);
        tick(14);
        chk("to_sig_c15", 32'(sig), 32'h2);
        chk("to_err_c15", 32'(error), 32'h0);
        tick(1);
        chk("to_err_c16", 32'(error), 32'h1);
        chk("to_sig_c16", 32'(sig), 32'h0);
        chk("to_busy_c16", 32'(busy), 32'h0);
        arriveReq = 1'b1;
        tick(1);
        arriveReq = 1'b0;
        chk("err_ignores_req", 32'(error), 32'h1);
        chk("err_sig_held0", 32'(sig), 32'h0);
        clearErr = 1'b1;
        tick(1);
        clearErr = 1'b0;
        chk("clr_err", 32'(error), 32'h0);
        chk("clr_busy", 32'(busy), 32'h0);
        ack_en = 1'b1;
        tick(4);

        // Simultaneous requests: arrive wins, depart never follows
        n0 = cyc;
        push_seg(2'b01, n0 + 1, n0 + 10, 1'b1);
        arriveReq = 1'b1;
        departReq = 1'b1;
        tick(1);
        arriveReq = 1'b0;
        departReq = 1'b0;
        chk("tie_sig", 32'(sig), 32'h1);
        tick(30);
        chk("tie_idle", 32'(busy), 32'h0);

        // Reset between edges mid-ASSERT
        n0 = cyc;
        push_seg(2'b01, n0 + 1, n0 + 4, 1'b0);
        arriveReq = 1'b1;
        tick(1);
        arriveReq = 1'b0;
        tick(3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_sig", 32'(sig), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        #3;
        reset = 1'b0;
        tick(3);
        run_nominal("post_rst");
        tick(3);

        // Wrong-direction ack during arrival
        n0 = cyc;
        push_seg(2'b01, n0 + 1, n0 + 4, 1'b0);
        arriveReq = 1'b1;
        tick(1);
        arriveReq = 1'b0;
        tick(2);
        force_dep = 1'b1;
        tick(1);
        chk("wrong_ack_err", 32'(error), 32'h1);
        chk("wrong_ack_sig", 32'(sig), 32'h0);
        force_dep = 1'b0;
        clearErr = 1'b1;
        tick(1);
        clearErr = 1'b0;
        chk("wrong_ack_clr", 32'(error), 32'h0);
        tick(4);

        // Depart request at cycle 3 of an arrival
        n0 = cyc;
        push_seg(2'b01, n0 + 1, n0 + 10, 1'b1);
`ifdef BATH_REQ_QUEUE_EN
        push_seg(2'b10, n0 + 12, n0 + 21, 1'b1);
`endif
        arriveReq = 1'b1;
        tick(1);
        arriveReq = 1'b0;
        gaps = (busy == 1'b1) ? 0 : 1;
        tick(2);
        departReq = 1'b1;
        tick(1);
        departReq = 1'b0;
        gaps += (busy == 1'b1) ? 0 : 1;
`ifdef BATH_REQ_QUEUE_EN
        for (int i = 5; i <= 22; i++) begin
            tick(1);
            gaps += (busy == 1'b1) ? 0 : 1;
        end
        chk("q_busy_held", 32'(gaps), 32'd0);
        tick(1);
        chk("q_idle", 32'(busy), 32'h0);
`else
        for (int i = 5; i <= 11; i++) begin
            tick(1);
            gaps += (busy == 1'b1) ? 0 : 1;
        end
        chk("nq_busy_held", 32'(gaps), 32'd0);
        tick(1);
        chk("nq_idle", 32'(busy), 32'h0);
`endif
        tick(20);
        chk("nq_still_idle", 32'(busy), 32'h0);

        tick(3);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
